turbo_out_packer: RTL and testbench
===================================

# turbo_out_packer

Downstream stage of the turbo encoder. Consumes the serial bit-pair stream (`out0`, `out1`, `valid`) and packs pairs into WORD_W-bit words. Buffers words in a small FIFO and presents them on a valid/ready master interface, with a last-word flag per encoded frame. Feeds the channel/host-side word interface.

## Interface
- `WORD_W`, 8: output word width; even, ≥ 4.
- `FRAME_PAIRS`, 66: bit pairs per encoded frame (payload + termination); ≥ 1.
- `FIFO_DEPTH`, 4: word FIFO entries; power of two, ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_N` in 1: asynchronous, active-low reset.
- `out0_in` in 1: encoder serial bit 0.
- `out1_in` in 1: encoder serial bit 1.
- `valid_in` in 1: pair qualifier; no backpressure to the encoder.
- `m_data` out WORD_W: FIFO head word.
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: consumer accepts the head when high together with `m_valid`.
- `m_last` out 1: head word is the final word of a frame.
- `overflow` out 1: sticky; a completed word was dropped.
- `frame_cnt` out 16: frames whose last word was pushed; wraps mod 2^16.

## Operation
- Pair sampling:
  - A pair is taken on each rising edge with `valid_in`=1.
  - Pair k within the current word occupies bits [2k+1:2k]: `out0_in` → bit 2k, `out1_in` → bit 2k+1.
  - k runs from 0 to WORD_W/2−1.
- Pair counter `pcnt`: 0..FRAME_PAIRS−1, counts accepted pairs in the current frame. Slot counter `slot`: 0..WORD_W/2−1.
- Word completion: the accepted pair is the last slot (`slot`=WORD_W/2−1) or the last pair of the frame (`pcnt`=FRAME_PAIRS−1).
- On completion:
  - The assembled word (shift register merged with the incoming pair) is pushed with last = (`pcnt`=FRAME_PAIRS−1).
  - Unused upper bits are 0.
  - `slot` clears; the shift register clears.
- Frame end:
  - On the last pair, `pcnt` returns to 0.
  - `frame_cnt` increments on the same edge, whether the push succeeds or the word is dropped.
- Push while FIFO full with no pop in the same cycle:
  - The word is dropped and `overflow` sets.
  - Counters still advance, so frame alignment is kept.
- A push and a pop in the same cycle when full both succeed.
- A push and a pop in the same cycle when empty: the pushed word becomes the head. There is no fall-through; `m_valid` rises the next cycle.
- `m_data`/`m_last` hold steady while `m_valid`=1 and `m_ready`=0.
- `valid_in` gaps of any length are legal; state holds.
- Reset is the only way to clear `overflow`.

## Timing
- Reset (asynchronous assert, any time, including mid-frame):
  - `m_valid`=0, `m_last`=0, `m_data`=0, `overflow`=0, `frame_cnt`=0.
  - `pcnt`=0, `slot`=0, FIFO empty; partial word discarded.
- First `valid_in` after reset deassertion is pair 0 of a new frame.
- Latency: completing pair sampled at edge N → word at FIFO head with `m_valid`=1 from edge N (visible in cycle N+1), if FIFO was empty.
- Pop occurs on an edge with `m_valid`·`m_ready`=1; the next head (or `m_valid`=0) is visible after that edge.
- Throughput: one pair per cycle sustained with `m_ready` held high; the FIFO never exceeds 1 entry.
- `frame_cnt` updates on the same edge as the last-word push.

## Structure
- Shared package `turbo_pkg`: `WORD_W`, `FRAME_PAIRS` defaults, and the `FRAME_CNT_W`=16 constant, shared with the encoder side.
- Sub-module `sync_fifo` (params WIDTH=WORD_W+1, DEPTH):
  - Registered head, full/empty flags, simultaneous push/pop.
  - Entry = {last, word}.
- Top level holds the pair/slot counters, shift register, overflow and frame_cnt logic.

## Test plan
- Defaults, `m_ready`=1, one frame of 66 pairs, all pairs (1,0):
  - 17 words: 16 × 0x55, then 0x05 with `m_last`=1.
  - `frame_cnt`=1, `overflow`=0.
- `m_ready`=0 for a full frame:
  - FIFO holds 4 words; the 5th completion sets `overflow`=1.
  - After `m_ready`=1, exactly 4 words drain, none with `m_last`; `frame_cnt`=1.
- Random `valid_in` gaps (~50%) and random `m_ready`, 3 back-to-back frames:
  - Word stream matches the reference packing model.
  - `m_last` on words 17, 34, 51; `frame_cnt`=3.
- Assert `rst_N` low after 30 pairs of a frame, release, then send a full frame:
  - Outputs reset immediately.
  - The next 17 words correspond only to the new frame; `frame_cnt`=1.
- FIFO full, with a push and a pop on the same edge:
  - No overflow; occupancy stays 4; word order is preserved.
- `FRAME_PAIRS`=4, `WORD_W`=8, pairs (1,1):
  - Each frame yields one word 0xFF with `m_last`=1.

Source files
------------

// File: rtl/turbo_pkg.sv
// Constants shared between the turbo encoder and its output-side stages.
package turbo_pkg;

    localparam int unsigned WORD_W_DEF      = 8;
    localparam int unsigned FRAME_PAIRS_DEF = 66;
    localparam int unsigned FRAME_CNT_W     = 16;

    // FIFO operation for one edge, encoded as {write, read}.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with the head entry read straight from storage registers.
// A write is accepted when full only if a read happens on the same edge.
module sync_fifo
    import turbo_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W_DEF + 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;
    fifo_op_e         op;

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign op    = fifo_op_e'({wr_en, rd_en});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (op)
                FIFO_PUSH: count <= count + 1'b1;
                FIFO_POP:  count <= count - 1'b1;
                default:   count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW + 1)'(DEPTH));

endmodule

// File: rtl/turbo_out_packer.sv
// Packs the encoder's serial bit pairs into words, flags the last word of
// each frame and buffers words for a valid/ready consumer.
module turbo_out_packer
    import turbo_pkg::*;
#(
    parameter int unsigned WORD_W      = WORD_W_DEF,
    parameter int unsigned FRAME_PAIRS = FRAME_PAIRS_DEF,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_N,
    input  logic                   out0_in,
    input  logic                   out1_in,
    input  logic                   valid_in,
    output logic [WORD_W-1:0]      m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   overflow,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int unsigned SLOTS  = WORD_W / 2;
    localparam int unsigned SLOT_W = $clog2(SLOTS);
    localparam int unsigned PCNT_W = $clog2(FRAME_PAIRS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(FRAME_PAIRS - 1);

    logic [SLOT_W-1:0] slot;
    logic [PCNT_W-1:0] pcnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] word_next;
    logic              frame_end;
    logic              word_done;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W:0]   head;

    // Incoming pair merged into the partial word; upper slots stay zero
    // because the shift register is cleared at every completion.
    always_comb begin
        word_next = shreg;
        word_next[{slot, 1'b0} +: 2] = {out1_in, out0_in};
    end

    assign frame_end = (pcnt == PCNT_LAST);
    assign word_done = valid_in && ((slot == SLOT_LAST) || frame_end);
    assign pop       = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            slot      <= '0;
            pcnt      <= '0;
            shreg     <= '0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else if (valid_in) begin
            if (word_done) begin
                slot  <= '0;
                shreg <= '0;
            end else begin
                slot  <= slot + 1'b1;
                shreg <= word_next;
            end
            // Counters advance even when the word is dropped, keeping frame alignment.
            if (frame_end) begin
                pcnt      <= '0;
                frame_cnt <= frame_cnt + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            if (word_done && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_N),
        .push      (word_done),
        .push_data ({frame_end, word_next}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = head[WORD_W-1:0];
    assign m_last  = head[WORD_W];

endmodule

// File: tb/tb_turbo_out_packer.sv
// Bench for turbo_out_packer: scoreboarded word stream plus directed
// overflow, reset, full-FIFO and short-frame sequences.
module tb_turbo_out_packer;

    localparam int W  = 8;
    localparam int FP = 66;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_N;
    logic        out0_in, out1_in, valid_in, m_ready;
    logic [W-1:0] m_data;
    logic        m_valid, m_last, overflow;
    logic [15:0] frame_cnt;

    logic        v4, r4;
    logic [W-1:0] m_data4;
    logic        m_valid4, m_last4, ovf4;
    logic [15:0] fc4;

    turbo_out_packer dut (
        .clk       (clk),
        .rst_N     (rst_N),
        .out0_in   (out0_in),
        .out1_in   (out1_in),
        .valid_in  (valid_in),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    turbo_out_packer #(
        .WORD_W      (8),
        .FRAME_PAIRS (4),
        .FIFO_DEPTH  (4)
    ) dut4 (
        .clk       (clk),
        .rst_N     (rst_N),
        .out0_in   (out0_in),
        .out1_in   (out1_in),
        .valid_in  (v4),
        .m_data    (m_data4),
        .m_valid   (m_valid4),
        .m_ready   (r4),
        .m_last    (m_last4),
        .overflow  (ovf4),
        .frame_cnt (fc4)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } word_t;

    word_t exp_q[$];
    int    last_idx[$];
    int    words_rx = 0;
    bit    sb_on = 1'b0;
    bit    model_push = 1'b0;
    bit    rnd_ready = 1'b0;
    logic  ready_val = 1'b0;

    int           mslot, mpcnt;
    logic [W-1:0] mword;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // m_ready has a single driver; changes land 2 time units after the edge.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            m_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_val;
        end
    end

    always @(negedge clk) begin
        if (rst_N === 1'b1 && m_valid && m_ready) begin
            word_t e;
            words_rx++;
            if (m_last) last_idx.push_back(words_rx);
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got data=%0h last=%0b, required no word", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", 32'(m_data), 32'(e.data));
                    check("word_last", 32'(m_last), 32'(e.last));
                end
            end
        end
    end

    task automatic model_clear();
        mslot = 0;
        mpcnt = 0;
        mword = '0;
    endtask

    task automatic model_step(input logic b0, input logic b1);
        mword[2*mslot]   = b0;
        mword[2*mslot+1] = b1;
        if (mslot == W/2 - 1 || mpcnt == FP - 1) begin
            exp_q.push_back('{last: (mpcnt == FP - 1), data: mword});
            mword = '0;
            mslot = 0;
        end else begin
            mslot++;
        end
        mpcnt = (mpcnt == FP - 1) ? 0 : mpcnt + 1;
    endtask

    task automatic send_pair(input logic b0, input logic b1);
        out0_in  = b0;
        out1_in  = b1;
        valid_in = 1'b1;
        if (model_push) model_step(b0, b1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        valid_in   = 1'b0;
        v4         = 1'b0;
        r4         = 1'b0;
        sb_on      = 1'b0;
        model_push = 1'b0;
        rnd_ready  = 1'b0;
        exp_q.delete();
        model_clear();
        rst_N = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_N = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(n < 300), 32'd1);
    endtask

    typedef struct {
        logic         b0;
        logic         b1;
        logic [W-1:0] full_w;
        logic [W-1:0] tail_w;
    } vec_t;

    vec_t vt[4];

    initial begin
        int base, lb;
        out0_in = 1'b0;
        out1_in = 1'b0;
        valid_in = 1'b0;
        v4 = 1'b0;
        r4 = 1'b0;
        rst_N = 1'b0;

        vt[0] = '{1'b1, 1'b0, 8'h55, 8'h05};
        vt[1] = '{1'b0, 1'b1, 8'hAA, 8'h0A};
        vt[2] = '{1'b1, 1'b1, 8'hFF, 8'h0F};
        vt[3] = '{1'b0, 1'b0, 8'h00, 8'h00};

        // Constant-pattern frames, expected words taken from the table.
        do_reset();
        check("rst_m_valid",   32'(m_valid),   32'd0);
        check("rst_m_last",    32'(m_last),    32'd0);
        check("rst_m_data",    32'(m_data),    32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        ready_val = 1'b1;
        sb_on = 1'b1;
        base = words_rx;
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 16; w++) exp_q.push_back('{last: 1'b0, data: vt[r].full_w});
            exp_q.push_back('{last: 1'b1, data: vt[r].tail_w});
            for (int p = 0; p < FP; p++) send_pair(vt[r].b0, vt[r].b1);
            wait_drain("t1_drain");
            check("t1_frame_cnt", 32'(frame_cnt), 32'(r + 1));
        end
        check("t1_word_count", 32'(words_rx - base), 32'd68);
        check("t1_overflow", 32'(overflow), 32'd0);

        // Consumer stalled for a whole frame.
        do_reset();
        ready_val = 1'b0;
        @(posedge clk);
        #1;
        for (int p = 0; p < 16; p++) send_pair(1'b1, 1'b0);
        check("t2_valid_full", 32'(m_valid), 32'd1);
        check("t2_ovf_before", 32'(overflow), 32'd0);
        for (int p = 0; p < 4; p++) send_pair(1'b1, 1'b0);
        check("t2_ovf_set", 32'(overflow), 32'd1);
        for (int p = 0; p < FP - 20; p++) send_pair(1'b1, 1'b0);
        check("t2_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t2_head_hold", 32'(m_data), 32'h55);
        check("t2_head_last", 32'(m_last), 32'd0);
        base = words_rx;
        lb = last_idx.size();
        ready_val = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("t2_drained", 32'(words_rx - base), 32'd4);
        check("t2_no_last", 32'(last_idx.size() - lb), 32'd0);
        check("t2_empty", 32'(m_valid), 32'd0);
        check("t2_ovf_sticky", 32'(overflow), 32'd1);

        // Random gaps and random ready over three frames.
        do_reset();
        model_push = 1'b1;
        sb_on = 1'b1;
        rnd_ready = 1'b1;
        base = words_rx;
        lb = last_idx.size();
        for (int p = 0; p < 3 * FP; p++) begin
            send_pair(1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain("t3_drain");
        rnd_ready = 1'b0;
        ready_val = 1'b1;
        check("t3_word_count", 32'(words_rx - base), 32'd51);
        check("t3_last_count", 32'(last_idx.size() - lb), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (last_idx.size() > lb + i)
                check("t3_last_pos", 32'(last_idx[lb + i] - base), 32'(17 * (i + 1)));
        end
        check("t3_frame_cnt", 32'(frame_cnt), 32'd3);
        check("t3_overflow", 32'(overflow), 32'd0);

        // Reset in the middle of a frame.
        do_reset();
        ready_val = 1'b0;
        @(posedge clk);
        #1;
        for (int p = 0; p < 30; p++) send_pair(1'($urandom), 1'($urandom));
        check("t4_pre_valid", 32'(m_valid), 32'd1);
        check("t4_pre_ovf", 32'(overflow), 32'd1);
        #2;
        rst_N = 1'b0;
        #1;
        check("t4_rst_valid", 32'(m_valid), 32'd0);
        check("t4_rst_data", 32'(m_data), 32'd0);
        check("t4_rst_last", 32'(m_last), 32'd0);
        check("t4_rst_ovf", 32'(overflow), 32'd0);
        check("t4_rst_fcnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_N = 1'b1;
        model_clear();
        model_push = 1'b1;
        sb_on = 1'b1;
        ready_val = 1'b1;
        @(posedge clk);
        #1;
        base = words_rx;
        for (int p = 0; p < FP; p++) send_pair(1'($urandom), 1'($urandom));
        wait_drain("t4_drain");
        check("t4_word_count", 32'(words_rx - base), 32'd17);
        check("t4_frame_cnt", 32'(frame_cnt), 32'd1);

        // Full FIFO with push and pop on the same edge.
        do_reset();
        model_push = 1'b1;
        sb_on = 1'b1;
        ready_val = 1'b0;
        @(posedge clk);
        #1;
        base = words_rx;
        for (int p = 0; p < 4; p++) send_pair(1'($urandom), 1'($urandom));
        check("t5_latency_valid", 32'(m_valid), 32'd1);
        if (exp_q.size() > 0) check("t5_first_head", 32'(m_data), 32'(exp_q[0].data));
        for (int p = 0; p < 12; p++) send_pair(1'($urandom), 1'($urandom));
        for (int p = 0; p < 3; p++) send_pair(1'($urandom), 1'($urandom));
        check("t5_full_no_ovf", 32'(overflow), 32'd0);
        out0_in = 1'($urandom);
        out1_in = 1'($urandom);
        valid_in = 1'b1;
        ready_val = 1'b1;
        model_step(out0_in, out1_in);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        ready_val = 1'b0;
        check("t5_pushpop_ovf", 32'(overflow), 32'd0);
        check("t5_one_popped", 32'(words_rx - base), 32'd1);
        check("t5_still_valid", 32'(m_valid), 32'd1);
        @(posedge clk);
        #1;
        ready_val = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t5_occupancy", 32'(words_rx - base), 32'd5);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t5_drained", 32'(m_valid), 32'd0);

        // Four-pair frames on the second instance.
        do_reset();
        r4 = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 4; p++) begin
                out0_in = 1'b1;
                out1_in = 1'b1;
                v4 = 1'b1;
                @(posedge clk);
                #1;
                v4 = 1'b0;
            end
            check("t6_valid", 32'(m_valid4), 32'd1);
            check("t6_data", 32'(m_data4), 32'hFF);
            check("t6_last", 32'(m_last4), 32'd1);
            check("t6_frame_cnt", 32'(fc4), 32'(f + 1));
        end
        r4 = 1'b1;
        @(posedge clk);
        #1;
        check("t6_second_valid", 32'(m_valid4), 32'd1);
        check("t6_second_data", 32'(m_data4), 32'hFF);
        check("t6_second_last", 32'(m_last4), 32'd1);
        @(posedge clk);
        #1;
        r4 = 1'b0;
        check("t6_empty", 32'(m_valid4), 32'd0);
        check("t6_ovf", 32'(ovf4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
